// File: rtl/tsi_mem_responder.sv
// tsi_mem_responder: chip-side endpoint of the 32-bit TSI word stream.
// Parses host commands (cmd, addr_lo, addr_hi, len_lo, len_hi), performs
// 32-bit word accesses on a single-outstanding memory port, and returns
// read data on the TSI out channel.
//
// Ports:
//   clock, reset_n                   single clock, synchronous active-low reset
//   tsi_in_valid/ready/bits          host -> responder word stream
//   tsi_out_valid/ready/bits         responder -> host read-data stream
//   mem_req_valid/ready/write/addr/data  memory request (registered, held until accepted)
//   mem_resp_valid/data              memory response pulse (read data or write ack)
//   busy                             high whenever a transaction is in progress
//   err_illegal_cmd                  one-cycle pulse after a command word other than 0/1
//
// Optional build: define TSI_MEM_RESPONDER_STATS_EN to add saturating
// counters stat_rd_words, stat_wr_words and stat_cmds.
module tsi_mem_responder #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned LEN_BITS  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tsi_in_valid,
    output logic                 tsi_in_ready,
    input  logic [31:0]          tsi_in_bits,
    output logic                 tsi_out_valid,
    input  logic                 tsi_out_ready,
    output logic [31:0]          tsi_out_bits,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_write,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [31:0]          mem_req_data,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_data,
    output logic                 busy,
`ifdef TSI_MEM_RESPONDER_STATS_EN
    output logic [31:0]          stat_rd_words,
    output logic [31:0]          stat_wr_words,
    output logic [31:0]          stat_cmds,
`endif
    output logic                 err_illegal_cmd
);

    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [3:0] {
        CMD,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        WR_DATA,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_SEND
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   is_wr_q;
    logic                   is_wr_d;
    logic [LEN_BITS-1:0]    count_q;
    logic [LEN_BITS-1:0]    count_d;
    logic [ADDR_BITS-1:0]   addr_d;
    logic [WORD_BITS-1:0]   wdata_d;
    logic [WORD_BITS-1:0]   out_bits_d;
    logic                   out_valid_d;
    logic                   err_d;
    logic                   in_ready_d;
    logic                   req_valid_d;
    logic                   req_write_d;
    logic                   busy_d;

    logic in_fire;
    logic req_fire;
    logic out_fire;
    logic legal_cmd;

    assign in_fire   = tsi_in_valid && tsi_in_ready;
    assign req_fire  = mem_req_valid && mem_req_ready;
    assign out_fire  = tsi_out_valid && tsi_out_ready;
    assign legal_cmd = (tsi_in_bits == 32'd0) || (tsi_in_bits == 32'd1);

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        count_d     = count_q;
        addr_d      = mem_req_addr;
        wdata_d     = mem_req_data;
        out_bits_d  = tsi_out_bits;
        out_valid_d = tsi_out_valid;
        err_d       = 1'b0;

        unique case (state_q)
            CMD: begin
                if (in_fire) begin
                    if (legal_cmd) begin
                        is_wr_d = tsi_in_bits[0];
                        state_d = ADDR_LO;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR_LO: begin
                if (in_fire) begin
                    addr_d  = ADDR_BITS'({tsi_in_bits[31:2], 2'b00});
                    state_d = ADDR_HI;
                end
            end
            ADDR_HI: begin
                // Rebuild the full 64-bit address and keep only ADDR_BITS of it
                if (in_fire) begin
                    addr_d  = ADDR_BITS'({tsi_in_bits, 32'(mem_req_addr)});
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (in_fire) begin
                    count_d = LEN_BITS'(tsi_in_bits);
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                // Length high word carries nothing the word counter can hold
                if (in_fire) begin
                    state_d = is_wr_q ? WR_DATA : RD_REQ;
                end
            end
            WR_DATA: begin
                if (in_fire) begin
                    wdata_d = tsi_in_bits;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (req_fire) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_resp_valid) begin
                    if (count_q == '0) begin
                        state_d = CMD;
                    end else begin
                        addr_d  = mem_req_addr + ADDR_BITS'(4);
                        count_d = count_q - LEN_BITS'(1);
                        state_d = WR_DATA;
                    end
                end
            end
            RD_REQ: begin
                if (req_fire) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    out_bits_d  = mem_resp_data;
                    out_valid_d = 1'b1;
                    state_d     = RD_SEND;
                end
            end
            RD_SEND: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    if (count_q == '0) begin
                        state_d = CMD;
                    end else begin
                        addr_d  = mem_req_addr + ADDR_BITS'(4);
                        count_d = count_q - LEN_BITS'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            default: begin
                state_d = CMD;
            end
        endcase

        // Handshake outputs are registered, so decode them from the next state
        in_ready_d  = (state_d inside {CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, WR_DATA});
        req_valid_d = (state_d inside {WR_REQ, RD_REQ});
        req_write_d = (state_d == WR_REQ);
        busy_d      = (state_d != CMD);
    end

    // Output and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            is_wr_q         <= 1'b0;
            count_q         <= '0;
            mem_req_addr    <= '0;
            mem_req_data    <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_write   <= 1'b0;
            tsi_in_ready    <= 1'b0;
            tsi_out_valid   <= 1'b0;
            tsi_out_bits    <= '0;
            busy            <= 1'b0;
            err_illegal_cmd <= 1'b0;
        end else begin
            is_wr_q         <= is_wr_d;
            count_q         <= count_d;
            mem_req_addr    <= addr_d;
            mem_req_data    <= wdata_d;
            mem_req_valid   <= req_valid_d;
            mem_req_write   <= req_write_d;
            tsi_in_ready    <= in_ready_d;
            tsi_out_valid   <= out_valid_d;
            tsi_out_bits    <= out_bits_d;
            busy            <= busy_d;
            err_illegal_cmd <= err_d;
        end
    end

`ifdef TSI_MEM_RESPONDER_STATS_EN
    // Saturating traffic counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_rd_words <= '0;
            stat_wr_words <= '0;
            stat_cmds     <= '0;
        end else begin
            if (out_fire && (stat_rd_words != '1)) begin
                stat_rd_words <= stat_rd_words + 32'd1;
            end
            if ((state_q == WR_WAIT) && mem_resp_valid && (stat_wr_words != '1)) begin
                stat_wr_words <= stat_wr_words + 32'd1;
            end
            if ((state_q == CMD) && in_fire && legal_cmd && (stat_cmds != '1)) begin
                stat_cmds <= stat_cmds + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tsi_mem_responder.sv
// Directed bench for tsi_mem_responder: a TSI host driver, a memory model
// with programmable stall/latency, and hand-computed expected transactions.
module tb_tsi_mem_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        tsi_in_valid;
    logic        tsi_in_ready;
    logic [31:0] tsi_in_bits;
    logic        tsi_out_valid;
    logic        tsi_out_ready;
    logic [31:0] tsi_out_bits;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;
    logic        err_illegal_cmd;
`ifdef TSI_MEM_RESPONDER_STATS_EN
    logic [31:0] stat_rd_words;
    logic [31:0] stat_wr_words;
    logic [31:0] stat_cmds;
`endif

    always #5 clock = ~clock;

    tsi_mem_responder #(.ADDR_BITS(32), .LEN_BITS(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .tsi_in_valid   (tsi_in_valid),
        .tsi_in_ready   (tsi_in_ready),
        .tsi_in_bits    (tsi_in_bits),
        .tsi_out_valid  (tsi_out_valid),
        .tsi_out_ready  (tsi_out_ready),
        .tsi_out_bits   (tsi_out_bits),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
`ifdef TSI_MEM_RESPONDER_STATS_EN
        .stat_rd_words  (stat_rd_words),
        .stat_wr_words  (stat_wr_words),
        .stat_cmds      (stat_cmds),
`endif
        .err_illegal_cmd(err_illegal_cmd)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] tx_q[$];
    logic [31:0] out_q[$];
    req_t        req_q[$];
    int          req_cyc_q[$];
    logic [31:0] mem[logic [31:0]];
    int          lat = 0;
    int          mem_stall = 0;
    int          out_stall = 0;
    logic        resp_pending = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] resp_data = 32'h0;
    int          err_cnt = 0;
    int          out_rise_cyc = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        tx_q.push_back(w);
        tsi_in_valid = 1'b1;
        tsi_in_bits  = tx_q[0];
    endtask

    task automatic clear_logs();
        out_q.delete();
        req_q.delete();
        req_cyc_q.delete();
        out_rise_cyc = -1;
    endtask

    // One clock: sample handshakes before the edge, update models #1 after it
    task automatic step();
        logic        p_rst, p_in_f, p_req_v, p_req_r, p_req_w, p_out_v, p_out_r;
        logic [31:0] p_addr, p_data, p_obits;
        p_rst   = reset_n;
        p_in_f  = tsi_in_valid && tsi_in_ready;
        p_req_v = mem_req_valid;
        p_req_r = mem_req_ready;
        p_req_w = mem_req_write;
        p_addr  = mem_req_addr;
        p_data  = mem_req_data;
        p_out_v = tsi_out_valid;
        p_out_r = tsi_out_ready;
        p_obits = tsi_out_bits;
        @(posedge clock);
        #1;
        cyc++;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        if (p_rst && p_req_v && p_req_r) begin
            req_q.push_back('{wr: p_req_w, addr: p_addr, data: p_data});
            req_cyc_q.push_back(cyc);
            if (p_req_w) begin
                mem[p_addr] = p_data;
                resp_data   = 32'h0;
            end else begin
                resp_data = mem.exists(p_addr) ? mem[p_addr] : 32'h0;
            end
            resp_pending = 1'b1;
            resp_cnt     = lat;
        end
        if (resp_pending) begin
            if (resp_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = resp_data;
                resp_pending   = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
        if (p_rst && p_in_f) void'(tx_q.pop_front());
        tsi_in_valid = (tx_q.size() > 0);
        tsi_in_bits  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
        if (p_rst && p_out_v && p_out_r) out_q.push_back(p_obits);
        if (tsi_out_valid && !p_out_v && out_rise_cyc < 0) out_rise_cyc = cyc;
        if (p_rst && p_req_v && !p_req_r && mem_stall > 0) mem_stall--;
        if (p_rst && p_out_v && !p_out_r && out_stall > 0) out_stall--;
        mem_req_ready = (mem_stall == 0);
        tsi_out_ready = (out_stall == 0);
        if (p_rst && reset_n && p_req_v && !p_req_r)
            check("req_hold", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_data},
                  {1'b1, p_req_w, p_addr, p_data});
        if (p_rst && reset_n && p_out_v && !p_out_r)
            check("out_hold", {tsi_out_valid, tsi_out_bits}, {1'b1, p_obits});
        if (err_illegal_cmd) err_cnt++;
    endtask

    function automatic logic is_idle();
        return (tx_q.size() == 0) && !busy && !resp_pending && !tsi_out_valid;
    endfunction

    task automatic run(input int budget);
        int n = 0;
        while (!is_idle() && n < budget) begin
            step();
            n++;
        end
        check("done", is_idle(), 1'b1);
        repeat (3) step();
    endtask

    function automatic logic [127:0] req_at(input int i);
        return (i < req_q.size()) ? 128'(req_q[i]) : '1;
    endfunction

    function automatic logic [127:0] out_at(input int i);
        return (i < out_q.size()) ? 128'(out_q[i]) : '1;
    endfunction

    initial begin
        logic seen;
        reset_n        = 1'b0;
        tsi_in_valid   = 1'b0;
        tsi_in_bits    = 32'h0;
        tsi_out_ready  = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        repeat (3) step();
        check("reset_outs", {tsi_in_ready, tsi_out_valid, tsi_out_bits, mem_req_valid, mem_req_write,
                             mem_req_addr, mem_req_data, busy, err_illegal_cmd}, '0);
        reset_n = 1'b1;
        step();
        check("idle_ready", {tsi_in_ready, busy}, 2'b10);

        // Two-word write at 0x80000000 with zero-latency memory
        clear_logs();
        lat = 0;
        push(32'd1); push(32'h8000_0000); push(32'd0); push(32'd1); push(32'd0);
        push(32'hDEAD_BEEF); push(32'hCAFE_F00D);
        run(200);
        check("wr_count", req_q.size(), 2);
        check("wr0", req_at(0), {1'b1, 32'h8000_0000, 32'hDEAD_BEEF});
        check("wr1", req_at(1), {1'b1, 32'h8000_0004, 32'hCAFE_F00D});
        if (req_cyc_q.size() == 2) check("wr_gap", req_cyc_q[1] - req_cyc_q[0], 3);
        check("wr_busy", busy, 1'b0);

        // Two-word read back with 2-cycle memory latency
        clear_logs();
        lat = 2;
        push(32'd0); push(32'h8000_0000); push(32'd0); push(32'd1); push(32'd0);
        run(200);
        check("rd_count", {req_q.size(), out_q.size()}, {32'd2, 32'd2});
        check("rd_req0", req_at(0) >> 32, {1'b0, 32'h8000_0000});
        check("rd_req1", req_at(1) >> 32, {1'b0, 32'h8000_0004});
        check("rd_out0", out_at(0), 32'hDEAD_BEEF);
        check("rd_out1", out_at(1), 32'hCAFE_F00D);
        if (req_cyc_q.size() > 0) check("rd_latency", out_rise_cyc - req_cyc_q[0], 3);

        // Backpressure on both memory request and TSI out
        clear_logs();
        lat = 1;
        mem_stall = 5;
        out_stall = 10;
        mem_req_ready = 1'b0;
        tsi_out_ready = 1'b0;
        push(32'd0); push(32'h8000_0004); push(32'd0); push(32'd0); push(32'd0);
        run(300);
        repeat (5) step();
        check("bp_count", {req_q.size(), out_q.size()}, {32'd1, 32'd1});
        check("bp_out", out_at(0), 32'hCAFE_F00D);
        check("bp_stalls_used", {mem_stall, out_stall}, 64'd0);

        // Illegal command then a legal read with an unaligned address
        clear_logs();
        lat = 0;
        err_cnt = 0;
        push(32'd7);
        run(50);
        check("ill_pulse", err_cnt, 1);
        check("ill_ready", {tsi_in_ready, busy}, 2'b10);
        mem[32'h1000] = 32'h1234_5678;
        push(32'd0); push(32'h0000_1003); push(32'd0); push(32'd0); push(32'd0);
        run(200);
        check("ill_rd_req", {req_q.size(), req_at(0) >> 32}, {32'd1, 128'({1'b0, 32'h0000_1000})});
        check("ill_rd_out", out_at(0), 32'h1234_5678);
        check("ill_no_err", err_cnt, 1);

        // Address truncation, wrap, and ignored len_hi
        clear_logs();
        push(32'd1); push(32'hFFFF_FFFC); push(32'd1); push(32'd1); push(32'd5);
        push(32'h1111_1111); push(32'h2222_2222);
        run(200);
        check("wrap_count", req_q.size(), 2);
        check("wrap0", req_at(0), {1'b1, 32'hFFFF_FFFC, 32'h1111_1111});
        check("wrap1", req_at(1), {1'b1, 32'h0000_0000, 32'h2222_2222});

        // Reset during RD_WAIT; the late response must be ignored
        clear_logs();
        lat = 4;
        push(32'd0); push(32'h0000_2000); push(32'd0); push(32'd0); push(32'd0);
        for (int i = 0; i < 50 && req_q.size() == 0; i++) step();
        check("rst_req_seen", req_q.size(), 1);
        step();
        check("rst_in_wait", {busy, tsi_out_valid, tsi_in_ready}, 3'b100);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            seen = seen | tsi_out_valid | busy;
        end
        check("rst_ignored", {seen, resp_pending, out_q.size()}, 34'd0);
        clear_logs();
        lat = 0;
        push(32'd0); push(32'h8000_0000); push(32'd0); push(32'd0); push(32'd0);
        run(200);
        check("rst_after_rd", {out_q.size(), out_at(0)}, {32'd1, 128'(32'hDEAD_BEEF)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
